dm_sweep_ctrl: RTL and testbench
================================

Name: dm_sweep_ctrl

Overview:
- Upstream driver for the 64-word data-memory block: generates Mem_Write, word address and write data, replacing the manual switch inputs.
- On a debounced start press, writes a selectable pattern to all 64 words, reads every word back and compares, then reports pass/fail.
- Presents a display word for the downstream seven-segment LED driver.

Parameters:
- DB_CYCLES, 20'd1000000, cycles start must be stable before the debounced level changes (benches use 4)
- RD_LAT, 2'd1, cycles from address presentation to valid rd_data
- DEPTH_LOG2, 6, address width; word count = 2**DEPTH_LOG2

Ports:
- clk  in  1  system clock; also the memory clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  raw push-button, active high, asynchronous to clk
- mode  in  2  pattern seed select, sampled at sweep launch
- rd_data  in  32  memory read data (M_R_Data)
- mem_write  out  1  memory write strobe
- dm_addr  out  DEPTH_LOG2  word address
- wr_data  out  32  memory write data
- busy  out  1  sweep in progress
- done  out  1  sticky, last sweep finished
- err  out  1  sticky, last sweep had at least one mismatch
- err_addr  out  DEPTH_LOG2  first mismatching address
- disp_data  out  32  word for LED driver

Behaviour:
- Reset (rst_n=0 at a clk edge): mem_write=0, dm_addr=0, wr_data=0, busy=0, done=0, err=0, err_addr=0, disp_data=0; FSM=IDLE; debounce counter and state cleared; mode latch = 0.
- Input sync: start passes through a 2-flop synchronizer, then the debouncer. The debounced level flips only after the synced value differs from it for DB_CYCLES consecutive cycles; any return resets the counter. launch = rising edge of the debounced level (single-cycle pulse).
- Seed by latched mode: 00→32'h2, 01→32'h3, 10→32'h6, 11→32'h7. Pattern(a) = seed + zero-extended a, 32-bit wrap.
- FSM states:
  - IDLE: on launch, latch mode, clear done/err/err_addr, set busy=1, dm_addr=0, go to WRITE.
  - WRITE: mem_write=1, wr_data=Pattern(dm_addr). If dm_addr is the last address, go to RADDR with dm_addr=0; otherwise dm_addr+1. Exactly 2**DEPTH_LOG2 write cycles; mem_write deasserts on the cycle WRITE exits.
  - RADDR: mem_write=0, hold dm_addr. Go to RWAIT with wait counter = RD_LAT.
  - RWAIT: decrement the counter; at 0 go to CHECK. RD_LAT=0 goes straight to CHECK.
  - CHECK: compare rd_data to Pattern(dm_addr).
    - On the first mismatch of the sweep, set err=1 and err_addr=dm_addr; later mismatches do not overwrite err_addr.
    - Not the last address: increment dm_addr, go to RADDR. Last address: go to FIN.
  - FIN: busy=0, done=1, back to IDLE.
- launch while busy is ignored (no restart, no queueing).
- disp_data: while busy, shows {26'b0, dm_addr}. After FIN: err=0 gives 32'h600D_0000 + seed; err=1 gives 32'hE000_0000 | err_addr. Before any sweep: 0.
- Reset mid-sweep aborts on that edge: mem_write drops immediately, and no partial status is retained.
- dm_addr wraps only via explicit reset to 0 at the WRITE→RADDR transition; it never increments past the last address.
- Total sweep, launch to done: 64 + 64×(RD_LAT+2) + 1 cycles (257 at RD_LAT=1, measured from the IDLE→WRITE cycle).

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles with start toggling → all outputs 0, busy never rises.
- Debounce: DB_CYCLES=4; start glitch high for 3 cycles, then a clean 10-cycle press → no launch from the glitch; exactly one sweep from the clean press; busy rises 2 (sync) + 4 (debounce) + 1 cycles after the press.
- Clean pass: behavioural RAM with RD_LAT=1, mode=2'b10 → 64 write strobes with wr_data at address 5 = 32'hB; done=1, err=0, disp_data=32'h600D_0006, sweep length 257 cycles.
- Fault injection: RAM model flips bit 0 at addresses 17 and 40 → err=1, err_addr=17, disp_data=32'hE000_0011.
- Ignore retrigger: second press mid-sweep → single sweep; done only once. Then a new press after done → done/err cleared at launch, new sweep with the newly latched mode=2'b01 (address 63 data = 32'h42).
- Mid-sweep reset: assert rst_n=0 during WRITE at address 30 → mem_write=0 on that edge, all status 0; the next press completes a clean sweep.

Source files
------------

// File: rtl/dm_sweep_ctrl.sv
// Purpose: self-test sweep driver for the 64-word data memory: debounced start,
//          writes a seeded pattern to every word, reads back, compares, reports.
// Ports:   clk/rst_n (sync active-low), start (raw button), mode (seed select),
//          rd_data (memory read data), mem_write/dm_addr/wr_data (memory drive),
//          busy/done/err/err_addr (status), disp_data (LED driver word).
// Latency: busy rises 2 sync + DB_CYCLES debounce + 1 cycles after a press; a
//          sweep takes 2**DEPTH_LOG2 * (RD_LAT + 3) + 1 cycles.
// Backpressure: none; start presses during a sweep are dropped.
module dm_sweep_ctrl #(
    parameter logic [19:0] DB_CYCLES  = 20'd1000000,
    parameter logic [1:0]  RD_LAT     = 2'd1,
    parameter int          DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [31:0]           rd_data,
    output logic                  mem_write,
    output logic [DEPTH_LOG2-1:0] dm_addr,
    output logic [31:0]           wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DEPTH_LOG2-1:0] err_addr,
    output logic [31:0]           disp_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RADDR,
        S_RWAIT,
        S_CHECK,
        S_FIN
    } state_t;

    // ------------------------------------------------------------------
    // Start button: 2-flop synchronizer followed by a level debouncer.
    // ------------------------------------------------------------------
    logic        start_s1;
    logic        start_s2;
    logic        db_lvl;
    logic        db_lvl_q;
    logic [19:0] db_cnt;
    logic        launch;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_s1 <= 1'b0;
            start_s2 <= 1'b0;
            db_lvl   <= 1'b0;
            db_lvl_q <= 1'b0;
            db_cnt   <= '0;
        end else begin
            start_s1 <= start;
            start_s2 <= start_s1;
            db_lvl_q <= db_lvl;
            if (start_s2 == db_lvl) begin
                // Any return to the current level restarts the stability count.
                db_cnt <= '0;
            end else if (db_cnt + 20'd1 >= DB_CYCLES) begin
                db_lvl <= start_s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 20'd1;
            end
        end
    end

    assign launch = db_lvl & ~db_lvl_q;

    // ------------------------------------------------------------------
    // Sweep FSM and status registers.
    // ------------------------------------------------------------------
    state_t                state, state_d;
    logic [DEPTH_LOG2-1:0] addr_d;
    logic                  busy_d;
    logic                  done_d;
    logic                  err_d;
    logic [DEPTH_LOG2-1:0] err_addr_d;
    logic [1:0]            mode_q, mode_d;
    logic [1:0]            wcnt, wcnt_d;

    logic [31:0] seed;
    logic [31:0] addr_ext;
    logic [31:0] err_addr_ext;
    logic [31:0] pattern;
    logic        last_addr;

    always_comb begin
        seed         = 32'h2;
        addr_ext     = '0;
        err_addr_ext = '0;
        case (mode_q)
            2'b00:   seed = 32'h2;
            2'b01:   seed = 32'h3;
            2'b10:   seed = 32'h6;
            default: seed = 32'h7;
        endcase
        addr_ext[DEPTH_LOG2-1:0]     = dm_addr;
        err_addr_ext[DEPTH_LOG2-1:0] = err_addr;
    end

    assign pattern   = seed + addr_ext;
    assign last_addr = (dm_addr == '1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            dm_addr  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_addr <= '0;
            mode_q   <= 2'b00;
            wcnt     <= 2'd0;
        end else begin
            state    <= state_d;
            dm_addr  <= addr_d;
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
            err_addr <= err_addr_d;
            mode_q   <= mode_d;
            wcnt     <= wcnt_d;
        end
    end

    always_comb begin
        state_d    = state;
        addr_d     = dm_addr;
        busy_d     = busy;
        done_d     = done;
        err_d      = err;
        err_addr_d = err_addr;
        mode_d     = mode_q;
        wcnt_d     = wcnt;
        mem_write  = 1'b0;
        wr_data    = '0;

        case (state)
            S_IDLE: begin
                if (launch) begin
                    mode_d     = mode;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    err_addr_d = '0;
                    busy_d     = 1'b1;
                    addr_d     = '0;
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_write = 1'b1;
                wr_data   = pattern;
                if (last_addr) begin
                    addr_d  = '0;
                    state_d = S_RADDR;
                end else begin
                    addr_d = dm_addr + 1'b1;
                end
            end
            S_RADDR: begin
                // Address is already on dm_addr; give the memory RD_LAT cycles.
                wcnt_d  = RD_LAT;
                state_d = (RD_LAT == 2'd0) ? S_CHECK : S_RWAIT;
            end
            S_RWAIT: begin
                if (wcnt <= 2'd1) begin
                    wcnt_d  = 2'd0;
                    state_d = S_CHECK;
                end else begin
                    wcnt_d = wcnt - 2'd1;
                end
            end
            S_CHECK: begin
                // Only the first mismatch of a sweep is recorded.
                if ((rd_data != pattern) && !err) begin
                    err_d      = 1'b1;
                    err_addr_d = dm_addr;
                end
                if (last_addr) begin
                    state_d = S_FIN;
                end else begin
                    addr_d  = dm_addr + 1'b1;
                    state_d = S_RADDR;
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // LED word: live address while sweeping, verdict afterwards.
    // ------------------------------------------------------------------
    always_comb begin
        disp_data = '0;
        if (busy) begin
            disp_data = addr_ext;
        end else if (done) begin
            disp_data = err ? (32'hE000_0000 | err_addr_ext)
                            : (32'h600D_0000 + seed);
        end
    end

endmodule

// File: tb/tb_dm_sweep_ctrl.sv
module tb_dm_sweep_ctrl;

    localparam int DL = 6;
    localparam int NW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    mode;
    logic [31:0]   rd_data;
    logic          mem_write;
    logic [DL-1:0] dm_addr;
    logic [31:0]   wr_data;
    logic          busy;
    logic          done;
    logic          err;
    logic [DL-1:0] err_addr;
    logic [31:0]   disp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_sweep_ctrl #(
        .DB_CYCLES (20'd4),
        .RD_LAT    (2'd1),
        .DEPTH_LOG2(DL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .rd_data  (rd_data),
        .mem_write(mem_write),
        .dm_addr  (dm_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_addr (err_addr),
        .disp_data(disp_data)
    );

    // Behavioural RAM, one-cycle registered read, optional bit-0 corruption.
    logic [31:0] mem [NW];
    bit          fault [NW];

    always @(posedge clk) begin
        if (mem_write) mem[dm_addr] <= wr_data;
        rd_data <= mem[dm_addr] ^ {31'b0, fault[dm_addr]};
    end

    typedef struct {
        logic [DL-1:0] a;
        logic [31:0]   d;
    } wr_t;

    typedef struct {
        logic          e;
        logic [DL-1:0] ea;
        logic [31:0]   disp;
    } st_t;

    wr_t exp_wr[$];
    st_t exp_st[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference model: what a full sweep with the given mode and fault map produces.
    task automatic push_sweep(input logic [1:0] m);
        logic [31:0] s;
        st_t         st;
        wr_t         w;
        s = (m == 2'd0) ? 32'h2 : (m == 2'd1) ? 32'h3 : (m == 2'd2) ? 32'h6 : 32'h7;
        for (int a = 0; a < NW; a++) begin
            w.a = DL'(a);
            w.d = s + 32'(a);
            exp_wr.push_back(w);
        end
        st.e  = 1'b0;
        st.ea = '0;
        for (int a = NW - 1; a >= 0; a--) begin
            if (fault[a]) begin
                st.e  = 1'b1;
                st.ea = DL'(a);
            end
        end
        st.disp = st.e ? (32'hE000_0000 + 32'(st.ea)) : (32'h600D_0000 + s);
        exp_st.push_back(st);
    endtask

    // Monitor: pops expectations whenever the DUT writes or finishes a sweep.
    int  ncyc = 0;
    int  sweep_start = 0;
    bit  busy_prev = 1'b0;
    bit  done_prev = 1'b0;

    always @(negedge clk) begin
        wr_t e;
        st_t s;
        ncyc++;
        if (rst_n) begin
            if (busy && !busy_prev) begin
                sweep_start = ncyc;
                chk("launch_done_clr", 32'(done), 32'd0);
                chk("launch_err_clr", 32'(err), 32'd0);
            end
            if (mem_write) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual addr=%0d expected no write", dm_addr);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", 32'(dm_addr), 32'(e.a));
                    chk("wr_data", wr_data, e.d);
                    chk("busy_disp", disp_data, 32'(e.a));
                end
            end
            if (done && !done_prev) begin
                if (exp_st.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual done=1 expected no sweep");
                end else begin
                    s = exp_st.pop_front();
                    chk("err", 32'(err), 32'(s.e));
                    chk("err_addr", 32'(err_addr), 32'(s.ea));
                    chk("disp_final", disp_data, s.disp);
                    chk("sweep_len", 32'(ncyc - sweep_start), 32'd257);
                    chk("busy_after_fin", 32'(busy), 32'd0);
                end
            end
        end
        busy_prev = busy;
        done_prev = done;
    end

    // Hold start high for hi cycles; lat = first cycle busy seen high, -1 if never.
    task automatic do_press(input int hi, output int lat);
        lat = -1;
        @(posedge clk);
        #1 start = 1'b1;
        for (int i = 1; i <= hi + 12; i++) begin
            @(posedge clk);
            #1;
            if (busy && lat < 0) lat = i;
            if (i >= hi) start = 1'b0;
        end
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual busy=1 expected busy=0", nm);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clear_faults();
        for (int a = 0; a < NW; a++) fault[a] = 1'b0;
    endtask

    initial begin
        int  lat;
        int  n;
        bit  seen;
        logic [1:0] m;

        rst_n = 1'b0;
        start = 1'b0;
        mode  = 2'b00;
        clear_faults();

        // Reset with start toggling.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 start = ~start;
        end
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_dm_addr", 32'(dm_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_addr", 32'(err_addr), 32'd0);
        chk("rst_disp", disp_data, 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (busy) seen = 1'b1;
        end
        chk("idle_no_busy", 32'(seen), 32'd0);

        // 3-cycle glitch must not launch.
        do_press(3, lat);
        chk("glitch_no_launch", 32'(lat), 32'hFFFF_FFFF);

        // Clean pass, mode 10.
        mode = 2'b10;
        push_sweep(2'b10);
        do_press(10, lat);
        chk("press_latency", 32'(lat), 32'd7);
        wait_idle("clean");
        chk("clean_disp", disp_data, 32'h600D_0006);

        // Fault injection at 17 and 40.
        fault[17] = 1'b1;
        fault[40] = 1'b1;
        mode = 2'b00;
        push_sweep(2'b00);
        do_press(10, lat);
        wait_idle("fault");
        chk("fault_err_addr", 32'(err_addr), 32'd17);
        chk("fault_disp", disp_data, 32'hE000_0011);
        clear_faults();

        // Retrigger mid-sweep is ignored.
        mode = 2'b11;
        push_sweep(2'b11);
        do_press(10, lat);
        repeat (50) @(posedge clk);
        #1 mode = 2'b01;
        do_press(10, lat);
        wait_idle("retrig");
        repeat (40) @(posedge clk);
        #1;
        chk("retrig_no_restart", 32'(busy), 32'd0);
        chk("retrig_disp", disp_data, 32'h600D_0007);

        // New press after done latches mode 01.
        push_sweep(2'b01);
        do_press(10, lat);
        wait_idle("mode01");
        chk("mode01_disp", disp_data, 32'h600D_0003);

        // Reset during WRITE at address 30.
        mode = 2'b10;
        push_sweep(2'b10);
        do_press(10, lat);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(mem_write && dm_addr == 6'd30) && n < 300);
        chk("reach_addr30", 32'(mem_write && dm_addr == 6'd30), 32'd1);
        rst_n = 1'b0;
        exp_wr.delete();
        exp_st.delete();
        @(posedge clk);
        #1;
        chk("midrst_mem_write", 32'(mem_write), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_dm_addr", 32'(dm_addr), 32'd0);
        chk("midrst_disp", disp_data, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        push_sweep(2'b10);
        do_press(10, lat);
        chk("post_rst_latency", 32'(lat), 32'd7);
        wait_idle("post_rst");

        // Randomized sweeps: random mode and random fault map.
        for (int it = 0; it < 3; it++) begin
            m = 2'($urandom_range(0, 3));
            clear_faults();
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) fault[$urandom_range(0, NW - 1)] = 1'b1;
            mode = m;
            push_sweep(m);
            do_press($urandom_range(8, 14), lat);
            wait_idle("rand");
        end

        chk("exp_wr_drained", 32'(exp_wr.size()), 32'd0);
        chk("exp_st_drained", 32'(exp_st.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
